// File: rtl/keypad_pkg.sv
// Shared types for the keypad row reader: geometry, debounce states,
// scan-result encoding and small combinational helpers.
package keypad_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;
    localparam int CODE_W   = 5;
    localparam int CIDX_W   = 3;

    typedef logic [NUM_COLS-1:0] col_t;
    typedef logic [NUM_ROWS-1:0] row_t;
    typedef logic [NUM_KEYS-1:0] img_t;
    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [CIDX_W-1:0]   cidx_t;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_e;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_KEY,
        RES_MULTI
    } scan_kind_e;

    typedef struct packed {
        logic       valid;
        scan_kind_e kind;
        code_t      code;
    } scan_res_t;

    function automatic logic is_onehot(col_t v);
        return (v != '0) && ((v & (v - col_t'(1))) == '0);
    endfunction

    function automatic cidx_t col_index(col_t v);
        cidx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (v[i]) begin
                idx = cidx_t'(i);
            end
        end
        return idx;
    endfunction

    // Classify a full image; code is only meaningful for RES_KEY.
    function automatic scan_res_t classify(img_t img);
        scan_res_t r;
        int        n;
        r = '0;
        n = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (img[i]) begin
                n++;
                r.code = CODE_W'(i);
            end
        end
        if (n == 0) begin
            r.kind = RES_NONE;
        end else if (n == 1) begin
            r.kind = RES_KEY;
        end else begin
            r.kind = RES_MULTI;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_row_reader_if.sv
// Column strobe / row return inputs and debounced key outputs.
// The slave side is the reader; the master side drives the matrix.
interface keypad_row_reader_if;
    import keypad_pkg::*;

    col_t  col_sel;
    row_t  row_in;
    code_t key_code;
    logic  key_valid;
    logic  key_held;
    logic  multi_err;

    modport master (
        output col_sel,
        output row_in,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  multi_err
    );

    modport slave (
        input  col_sel,
        input  row_in,
        output key_code,
        output key_valid,
        output key_held,
        output multi_err
    );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous row return lines,
// cleared by the asynchronous active-low reset.
module keypad_row_sync
    import keypad_pkg::*;
#(
    parameter int WIDTH = NUM_ROWS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] row_i,
    output logic [WIDTH-1:0] row_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Two-stage capture of the raw rows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= row_i;
            s2_q <= s1_q;
        end
    end

    assign row_o = s2_q;

endmodule

// File: rtl/keypad_row_reader.sv
// Keypad row reader: builds a 5x4 image per column cycle, classifies
// each complete scan and debounces single-key results across scans.
module keypad_row_reader
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 3,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic               clk,
    input  logic               rstn,
    keypad_row_reader_if.slave kp
);

    localparam logic [7:0] SET_N     = 8'(SETTLE_CYCLES);
    localparam logic [7:0] DEB_N     = 8'(DEBOUNCE_SCANS);
    localparam col_t       COL_FIRST = col_t'(1);
    localparam col_t       COL_LAST  = col_t'(1) << (NUM_COLS - 1);

    row_t       rows_s;
    col_t       col_q, col_d;
    logic [7:0] set_q, set_d;
    logic       smp_q, smp_d;
    img_t       img_q, img_d;
    col_t       seen_q, seen_d;
    logic       bad_q, bad_d;
    scan_res_t  res_q, res_d;
    scan_res_t  cls;
    logic       chg;
    cidx_t      cidx;
    code_t      base;

    kp_state_e  st_q, st_d;
    code_t      cand_q, cand_d;
    code_t      code_q, code_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic       vld_q, vld_d;
    logic       merr_q, merr_d;
    logic       is_key;
    logic       same;
    logic [7:0] dnx;

    keypad_row_sync #(
        .WIDTH(NUM_ROWS)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .row_i(kp.row_in),
        .row_o(rows_s)
    );

    assign chg  = kp.col_sel != col_q;
    assign cls  = classify(img_q);
    assign cidx = col_index(col_q);
    assign base = code_t'(cidx) * code_t'(NUM_ROWS);

    // Column phase tracking, image assembly and scan completion.
    always_comb begin
        col_d  = kp.col_sel;
        set_d  = set_q;
        smp_d  = smp_q;
        img_d  = img_q;
        seen_d = seen_q;
        bad_d  = bad_q;
        res_d  = '0;
        if (chg) begin
            set_d = '0;
            smp_d = 1'b0;
            if (col_q == COL_LAST) begin
                res_d       = cls;
                res_d.valid = (&seen_q) && !bad_q;
                bad_d       = 1'b1;
            end
            if (kp.col_sel == COL_FIRST) begin
                img_d  = '0;
                seen_d = '0;
                bad_d  = 1'b0;
            end else if (!is_onehot(kp.col_sel)) begin
                bad_d = 1'b1;
            end
        end else begin
            if (set_q != SET_N) begin
                set_d = set_q + 8'd1;
            end
            if (set_q == SET_N && !smp_q && is_onehot(col_q)) begin
                img_d[base +: NUM_ROWS] = rows_s;
                seen_d[cidx]            = 1'b1;
                smp_d                   = 1'b1;
            end
        end
    end

    // Scan-side state; a fresh reset leaves the running scan marked bad.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q  <= '0;
            set_q  <= '0;
            smp_q  <= 1'b0;
            img_q  <= '0;
            seen_q <= '0;
            bad_q  <= 1'b1;
            res_q  <= '0;
        end else begin
            col_q  <= col_d;
            set_q  <= set_d;
            smp_q  <= smp_d;
            img_q  <= img_d;
            seen_q <= seen_d;
            bad_q  <= bad_d;
            res_q  <= res_d;
        end
    end

    // Debounce next-state; MULTI counts as NONE here.
    always_comb begin
        st_d   = st_q;
        cand_d = cand_q;
        dcnt_d = dcnt_q;
        code_d = code_q;
        vld_d  = 1'b0;
        merr_d = 1'b0;
        is_key = res_q.kind == RES_KEY;
        same   = is_key && (res_q.code == cand_q);
        dnx    = dcnt_q + 8'd1;
        if (res_q.valid) begin
            merr_d = res_q.kind == RES_MULTI;
            unique case (st_q)
                IDLE: begin
                    if (is_key) begin
                        cand_d = res_q.code;
                        if (DEB_N <= 8'd1) begin
                            st_d   = PRESSED;
                            code_d = res_q.code;
                            vld_d  = 1'b1;
                        end else begin
                            st_d   = DEBOUNCE;
                            dcnt_d = 8'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (same) begin
                        dcnt_d = dnx;
                        if (dnx >= DEB_N) begin
                            st_d   = PRESSED;
                            code_d = cand_q;
                            vld_d  = 1'b1;
                        end
                    end else if (is_key) begin
                        cand_d = res_q.code;
                        dcnt_d = 8'd1;
                    end else begin
                        st_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (!same) begin
                        if (DEB_N <= 8'd1) begin
                            st_d = IDLE;
                        end else begin
                            st_d   = RELEASE;
                            dcnt_d = 8'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (same) begin
                        st_d = PRESSED;
                    end else begin
                        dcnt_d = dnx;
                        if (dnx >= DEB_N) begin
                            st_d = IDLE;
                        end
                    end
                end
                default: begin
                    st_d = IDLE;
                end
            endcase
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q   <= IDLE;
            cand_q <= '0;
            dcnt_q <= '0;
            code_q <= '0;
            vld_q  <= 1'b0;
            merr_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cand_q <= cand_d;
            dcnt_q <= dcnt_d;
            code_q <= code_d;
            vld_q  <= vld_d;
            merr_q <= merr_d;
        end
    end

    assign kp.key_code  = code_q;
    assign kp.key_valid = vld_q;
    assign kp.key_held  = (st_q == PRESSED) || (st_q == RELEASE);
    assign kp.multi_err = merr_q;

endmodule

// File: tb/tb_keypad_row_reader.sv
// Randomized bench for keypad_row_reader against a scan-level
// reference model of the debounce rules.
module tb_keypad_row_reader;
    import keypad_pkg::*;

    localparam int   SETTLE = 3;
    localparam int   DEB    = 3;
    localparam col_t C0     = 5'b00001;
    localparam col_t C2     = 5'b00100;
    localparam col_t C3     = 5'b01000;
    localparam col_t C4     = 5'b10000;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    keypad_row_reader_if kp();

    keypad_row_reader #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          good;
        logic [19:0] img;
    } ev_t;

    ev_t         evq[$];
    int          cyc, n_chk, n_fail, n_vld, n_merr;
    bit          m_held, exp_v, exp_m;
    int          m_cand, m_code, m_run, m_rel;
    bit          pend_valid, pend_good;
    logic [19:0] pend_img;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_held = 0;
        m_cand = 0;
        m_code = 0;
        m_run  = 0;
        m_rel  = 0;
        exp_v  = 0;
        exp_m  = 0;
    endtask

    // One completed scan as seen by the debounce rules.
    task automatic apply(input ev_t e);
        int n;
        int key;
        if (!e.good) return;
        n   = $countones(e.img);
        key = -1;
        if (n > 1) exp_m = 1;
        if (n == 1) begin
            for (int i = 0; i < 20; i++) if (e.img[i]) key = i;
        end
        if (!m_held) begin
            if (key >= 0) begin
                m_run  = (m_run > 0 && key == m_cand) ? m_run + 1 : 1;
                m_cand = key;
            end else begin
                m_run = 0;
            end
            if (m_run >= DEB) begin
                m_held = 1;
                m_code = key;
                m_rel  = 0;
                exp_v  = 1;
            end
        end else begin
            if (key == m_cand) begin
                m_rel = 0;
            end else begin
                m_rel++;
                if (m_rel >= DEB) begin
                    m_held = 0;
                    m_run  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        exp_v = 0;
        exp_m = 0;
        while (evq.size() > 0 && evq[0].due <= cyc) begin
            apply(evq.pop_front());
        end
        if (kp.key_valid === 1'b1) n_vld++;
        if (kp.multi_err === 1'b1) n_merr++;
        chk("key_valid", 32'(kp.key_valid), 32'(exp_v));
        chk("multi_err", 32'(kp.multi_err), 32'(exp_m));
        chk("key_held", 32'(kp.key_held), 32'(m_held));
        chk("key_code", 32'(kp.key_code), m_code);
    endtask

    task automatic drive_phase(input col_t c, input row_t r, input int len);
        if (kp.col_sel == C4 && c != C4 && pend_valid) begin
            evq.push_back('{due: cyc + 2, good: pend_good, img: pend_img});
            pend_valid = 0;
        end
        kp.col_sel = c;
        kp.row_in  = r;
        repeat (len) tick();
    endtask

    // mode 0 normal, 1 one column too short, 2 invalid phase inserted
    task automatic run_scan(input logic [19:0] img, input int mode,
                            input int start);
        int   sc;
        col_t badc;
        sc = $urandom_range(0, 3);
        for (int c = start; c < NUM_COLS; c++) begin
            int len;
            len = $urandom_range(SETTLE + 2, SETTLE + 6);
            if (mode == 1 && c == sc) len = $urandom_range(1, SETTLE + 1);
            drive_phase(col_t'(1) << c, img[c*4 +: 4], len);
            if (mode == 2 && c == sc) begin
                unique case ($urandom_range(0, 2))
                    0: badc = 5'b00110;
                    1: badc = 5'b00000;
                    default: badc = 5'b11000;
                endcase
                drive_phase(badc, row_t'($urandom), 3);
            end
        end
        pend_valid = 1;
        pend_good  = (start == 0) && (mode == 0);
        pend_img   = img;
    endtask

    task automatic do_reset(input int hold);
        rstn = 1'b0;
        #1;
        chk("rst_code", 32'(kp.key_code), 0);
        chk("rst_valid", 32'(kp.key_valid), 0);
        chk("rst_held", 32'(kp.key_held), 0);
        chk("rst_merr", 32'(kp.multi_err), 0);
        model_reset();
        evq.delete();
        pend_valid = 0;
        repeat (hold) tick();
        rstn = 1'b1;
    endtask

    initial begin
        logic [19:0] k9, k0, kmul, img;
        int          v0, m0, a, b;
        k9   = 20'h0 | (20'h1 << 9);
        k0   = 20'h0;
        kmul = 20'h1 | (20'h1 << 19);
        kp.col_sel = '0;
        kp.row_in  = '0;
        model_reset();
        cyc = 0;
        @(posedge clk);
        #1;
        do_reset(4);

        run_scan(k0, 0, 2);
        v0 = n_vld;
        m0 = n_merr;
        repeat (3) run_scan(k0, 0, 0);
        chk("idle_valid", n_vld - v0, 0);
        chk("idle_merr", n_merr - m0, 0);

        v0 = n_vld;
        repeat (4) run_scan(k9, 0, 0);
        chk("press_once", n_vld - v0, 1);
        chk("press_code", 32'(kp.key_code), 9);
        chk("press_held", 32'(kp.key_held), 1);

        repeat (4) run_scan(k0, 0, 0);
        chk("rel_held", 32'(kp.key_held), 0);
        chk("rel_code", 32'(kp.key_code), 9);

        v0 = n_vld;
        run_scan(k9, 0, 0);
        run_scan(k0, 0, 0);
        run_scan(k9, 0, 0);
        repeat (3) run_scan(k0, 0, 0);
        chk("bounce_valid", n_vld - v0, 0);

        v0 = n_vld;
        m0 = n_merr;
        repeat (3) run_scan(kmul, 0, 0);
        run_scan(k0, 0, 0);
        chk("multi_cnt", n_merr - m0, 3);
        chk("multi_valid", n_vld - v0, 0);

        v0 = n_vld;
        run_scan(k9, 0, 0);
        run_scan(k9, 1, 0);
        run_scan(k9, 0, 0);
        run_scan(k9, 2, 0);
        run_scan(k9, 0, 0);
        chk("bad_early", n_vld - v0, 0);
        run_scan(k9, 0, 0);
        chk("bad_accept", n_vld - v0, 1);
        repeat (4) run_scan(k0, 0, 0);

        repeat (4) run_scan(k9, 0, 0);
        chk("pre_rst_held", 32'(kp.key_held), 1);
        drive_phase(C0, k9[3:0], 6);
        drive_phase(5'b00010, k9[7:4], 6);
        drive_phase(C2, k9[11:8], 3);
        do_reset(3);
        drive_phase(C2, k9[11:8], 6);
        drive_phase(C3, k9[15:12], 6);
        drive_phase(C4, k9[19:16], 6);
        pend_valid = 1;
        pend_good  = 0;
        pend_img   = k9;
        v0 = n_vld;
        repeat (3) run_scan(k9, 0, 0);
        chk("rst_early", n_vld - v0, 0);
        run_scan(k9, 0, 0);
        chk("rst_accept", n_vld - v0, 1);
        repeat (4) run_scan(k0, 0, 0);

        for (int blk = 0; blk < 16; blk++) begin
            int r;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 19);
            b = (a + $urandom_range(1, 19)) % 20;
            if (r < 4) img = k0;
            else if (r < 8) img = 20'h1 << a;
            else img = (20'h1 << a) | (20'h1 << b);
            repeat ($urandom_range(1, 5)) begin
                int md;
                md = $urandom_range(0, 9);
                run_scan(img, md < 8 ? 0 : md - 7, 0);
            end
        end

        drive_phase(5'b00000, 4'h0, 6);
        chk("drain", evq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_row_reader.md
# keypad_row_reader

Receive side of the 5-column keypad/matrix scan: the column decoder drives one-hot column strobes C0..C4; this block watches those strobes and samples the returned row lines. It synchronizes the rows, assembles one full 5×4 scan image per column cycle, debounces across whole scans and reports a single debounced key code to the irrigation controller's menu logic.

## Interface
- NUM_COLS, 5, column strobes per scan; fixed to match the column decoder
- NUM_ROWS, 4, row return lines
- SETTLE_CYCLES, 3, clocks a column must be stable, counted after row sync, before its rows are sampled; must be at least 1
- DEBOUNCE_SCANS, 3, consecutive identical scans required to accept a press or a release; must be at least 1
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- col_sel  in  NUM_COLS  column strobes C0..C4 as driven by the column decoder, active-high, expected one-hot
- row_in  in  NUM_ROWS  raw row returns, asynchronous, active-high (1 = key closed on active column)
- key_code  out  5  col*NUM_ROWS+row of the last accepted key, range 0..19; reset 0
- key_valid  out  1  one-cycle pulse on accepted press; reset 0
- key_held  out  1  high from accepted press until accepted release; reset 0
- multi_err  out  1  one-cycle pulse when a complete scan shows more than one closed key; reset 0

## Operation
- row_in passes through a 2-FF synchronizer before any use.
- Column phase: col_sel registered each cycle; a change starts a new phase and clears the settle counter. col_sel of zero or not one-hot is an invalid phase: no sampling, and the scan in progress is marked bad.
- Sampling: once per phase, after SETTLE_CYCLES stable cycles, the synced rows are written into the image slot for that column and the column's seen bit is set.
- Scan boundary: entry into C0 starts a scan (clears image and seen bits). Leaving C4 completes it. A completed scan is good only if all five seen bits are set and no invalid phase occurred; bad scans are discarded silently. The partial scan after reset is always bad.
- Scan result for a good scan: NONE (0 bits set), KEY(k) (exactly 1), MULTI (>1). MULTI pulses multi_err and is treated as NONE for debounce.
- Debounce FSM, count cnt:
  - IDLE: KEY(k) -> cand=k, cnt=1, DEBOUNCE; NONE stays.
  - DEBOUNCE: KEY(cand) -> cnt+1; KEY(j≠cand) -> cand=j, cnt=1; NONE -> IDLE. cnt reaching DEBOUNCE_SCANS -> PRESSED, key_code=cand, key_valid pulse, key_held=1.
  - PRESSED: KEY(cand) stays; anything else -> RELEASE, cnt=1.
  - RELEASE: KEY(cand) -> PRESSED, no new key_valid; other result -> cnt+1; cnt reaching DEBOUNCE_SCANS -> IDLE, key_held=0.
- With DEBOUNCE_SCANS=1, transitions go directly IDLE->PRESSED and PRESSED->IDLE.
- key_code holds its value after release until the next accepted press.
- rstn low at any time: FSM to IDLE, image, seen bits and counters cleared, all outputs 0 asynchronously.

## Timing
- Row input to sampled: 2 sync cycles, plus SETTLE_CYCLES after the column change.
- The scan-complete evaluation is registered. key_valid, multi_err, and key_held/key_code updates appear 2 clocks after the first cycle col_sel no longer shows C4 at the input.
- Minimum column phase length for a valid sample: SETTLE_CYCLES+2 clocks after the change. Shorter phases produce a bad scan.
- No handshake. key_valid is not held, and the consumer must capture it in the pulse cycle.

## Structure
- Package keypad_pkg holds NUM_COLS, NUM_ROWS, the FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE), and the scan-result encoding (NONE/KEY/MULTI).
- One sub-module, keypad_row_sync: the NUM_ROWS-wide 2-FF synchronizer with asynchronous active-low clear.

## Test plan
- Reset and idle: column model cycles C0..C4 at 8 clocks each, rows 0 -> all outputs stay 0; multi_err never pulses.
- Press C2/row1 held for 4 scans (DEBOUNCE_SCANS=3) -> a single key_valid 2 clocks after the 3rd scan leaves C4; key_code=9, key_held=1.
- Release after the press: rows 0 for 3 scans -> key_held falls after the 3rd; key_code stays 9. Bounce: 1 scan closed, 1 open, 1 closed -> no key_valid.
- Two keys, C0/row0 and C4/row3, for 3 scans -> multi_err pulses each scan; no key_valid.
- Column phase of 3 clocks inside a scan, or col_sel=5'b00110 -> that scan is discarded; a held key needs 3 further good scans to be accepted.
- rstn pulsed low mid-scan while PRESSED -> outputs 0 immediately; after release, key_valid re-asserts only after 3 good scans following the first full C0 entry.
